// File: rtl/move_scheduler_if.sv
// Maze-read and enable-publication bus between the move scheduler and its
// maze memory and movement controllers.
interface move_scheduler_if #(
    parameter int N_ENT = 4,
    parameter int X_W   = 5,
    parameter int Y_W   = 5
);
    localparam int ID_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

    logic            rd_en;
    logic [X_W-1:0]  rd_x;
    logic [Y_W-1:0]  rd_y;
    logic            rd_wall;
    logic            en_valid;
    logic [ID_W-1:0] en_id;
    logic            uE;
    logic            dE;
    logic            rE;
    logic            lE;
    logic            step;

    modport master (
        output rd_en, rd_x, rd_y,
        input  rd_wall,
        output en_valid, en_id, uE, dE, rE, lE, step
    );

    modport slave (
        input  rd_en, rd_x, rd_y,
        output rd_wall,
        input  en_valid, en_id, uE, dE, rE, lE, step
    );
endinterface

// File: rtl/move_scheduler.sv
// Game-tick sequencer: snapshots entity tiles, reads four neighbour walls per
// entity from the shared maze memory, publishes open directions, then steps.
module move_scheduler #(
    parameter int N_ENT    = 4,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int MAZE_W   = 28,
    parameter int MAZE_H   = 31,
    parameter int TICK_DIV = 2500000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [N_ENT*X_W-1:0]   ent_x,
    input  logic [N_ENT*Y_W-1:0]   ent_y,
    move_scheduler_if.master       bus,
    output logic                   busy,
    output logic                   overrun
);
    localparam int ID_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_ENT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_U,
        RD_D,
        RD_R,
        RD_L,
        WAIT,
        PUB,
        STEP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PS_W-1:0] r_presc;
    logic            w_tick;
    logic [ID_W-1:0] r_idx;
    logic [X_W-1:0]  r_snapX [N_ENT];
    logic [Y_W-1:0]  r_snapY [N_ENT];
    logic            r_wallU;
    logic            r_wallD;
    logic            r_wallR;
    logic            r_uE;
    logic            r_dE;
    logic            r_rE;
    logic            r_lE;
    logic            r_overrun;

    logic [X_W-1:0]  w_curX;
    logic [Y_W-1:0]  w_curY;
    logic            w_oor;
    logic            w_blkU;
    logic            w_blkD;
    logic            w_blkR;
    logic            w_blkL;
    logic [Y_W-1:0]  w_upY;
    logic [Y_W-1:0]  w_dnY;
    logic [X_W-1:0]  w_rtX;
    logic [X_W-1:0]  w_ltX;

    assign w_tick = run && (r_presc == PS_LAST);

    always_ff @(posedge clk) begin
        if (reset || !run || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    // The sweep works only from this snapshot so mid-sweep input motion is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENT; i++) begin
                r_snapX[i] <= '0;
                r_snapY[i] <= '0;
            end
        end else if (w_tick && (r_state == IDLE)) begin
            for (int i = 0; i < N_ENT; i++) begin
                r_snapX[i] <= ent_x[i*X_W +: X_W];
                r_snapY[i] <= ent_y[i*Y_W +: Y_W];
            end
        end
    end

    assign w_curX = r_snapX[r_idx];
    assign w_curY = r_snapY[r_idx];

    assign w_oor  = (32'(w_curX) >= MAZE_W) || (32'(w_curY) >= MAZE_H);
    assign w_blkU = (w_curY == '0);
    assign w_blkD = (32'(w_curY) >= MAZE_H - 1);
    assign w_blkR = (32'(w_curX) >= MAZE_W - 1);
    assign w_blkL = (w_curX == '0);

    // Off-grid neighbours are read at the entity's own tile to keep timing fixed.
    assign w_upY = w_blkU ? w_curY : w_curY - Y_W'(1);
    assign w_dnY = w_blkD ? w_curY : w_curY + Y_W'(1);
    assign w_rtX = w_blkR ? w_curX : w_curX + X_W'(1);
    assign w_ltX = w_blkL ? w_curX : w_curX - X_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wallU <= 1'b0;
            r_wallD <= 1'b0;
            r_wallR <= 1'b0;
            r_uE    <= 1'b0;
            r_dE    <= 1'b0;
            r_rE    <= 1'b0;
            r_lE    <= 1'b0;
        end else begin
            case (r_state)
                RD_D: r_wallU <= bus.rd_wall;
                RD_R: r_wallD <= bus.rd_wall;
                RD_L: r_wallR <= bus.rd_wall;
                WAIT: begin
                    r_uE <= !(w_oor || w_blkU || r_wallU);
                    r_dE <= !(w_oor || w_blkD || r_wallD);
                    r_rE <= !(w_oor || w_blkR || r_wallR);
                    r_lE <= !(w_oor || w_blkL || bus.rd_wall);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == IDLE)) begin
            r_idx <= '0;
        end else if ((r_state == PUB) && (r_idx != ID_LAST)) begin
            r_idx <= r_idx + ID_W'(1);
        end
    end

    // A tick that lands during a sweep is dropped and remembered here until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_tick && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.rd_en    = 1'b0;
        bus.rd_x     = '0;
        bus.rd_y     = '0;
        bus.en_valid = 1'b0;
        bus.step     = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_next = RD_U;
                end
            end
            RD_U: begin
                bus.rd_en = 1'b1;
                bus.rd_x  = w_curX;
                bus.rd_y  = w_upY;
                w_next    = RD_D;
            end
            RD_D: begin
                bus.rd_en = 1'b1;
                bus.rd_x  = w_curX;
                bus.rd_y  = w_dnY;
                w_next    = RD_R;
            end
            RD_R: begin
                bus.rd_en = 1'b1;
                bus.rd_x  = w_rtX;
                bus.rd_y  = w_curY;
                w_next    = RD_L;
            end
            RD_L: begin
                bus.rd_en = 1'b1;
                bus.rd_x  = w_ltX;
                bus.rd_y  = w_curY;
                w_next    = WAIT;
            end
            WAIT: begin
                w_next = PUB;
            end
            PUB: begin
                bus.en_valid = 1'b1;
                w_next       = (r_idx == ID_LAST) ? STEP : RD_U;
            end
            STEP: begin
                bus.step = 1'b1;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign bus.en_id = r_idx;
    assign bus.uE    = r_uE;
    assign bus.dE    = r_dE;
    assign bus.rE    = r_rE;
    assign bus.lE    = r_lE;
    assign overrun   = r_overrun;
endmodule
